// File: rtl/bias_ram_loader.sv
// rtl/bias_ram_loader.sv - write-side controller turning a bias stream into 1x1 bias RAM writes
module bias_ram_loader #(
  parameter int ADDR_BITS      = 9,
  parameter int BEATS_PER_ROW  = 4,
  parameter int GROUP_BITS     = 8,
  parameter int AXI_WIDTH_DATA = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [GROUP_BITS-1:0]     channel_out_groups,
  input  logic [AXI_WIDTH_DATA-1:0] S_Data,
  input  logic                      S_Valid,
  output logic                      S_Ready,
  output logic [AXI_WIDTH_DATA-1:0] input_data,
  output logic [ADDR_BITS-1:0]      write_address,
  output logic                      write_enable,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int TOTAL_BITS = ADDR_BITS + GROUP_BITS;
  localparam logic [TOTAL_BITS-1:0] CAPACITY = TOTAL_BITS'(64'd1 << ADDR_BITS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]            state;
  logic [TOTAL_BITS-1:0] total;
  logic [ADDR_BITS-1:0]  beat_count;
  logic                  err_flag;

  logic [TOTAL_BITS-1:0] requested;
  logic                  too_big;
  logic                  handshake;
  logic                  last_beat;

  // Full-width product so an oversized group count can never alias into range.
  assign requested = TOTAL_BITS'(channel_out_groups) * TOTAL_BITS'(BEATS_PER_ROW);
  assign too_big   = requested > CAPACITY;
  assign handshake = S_Valid && (state == LOAD);
  assign last_beat = (TOTAL_BITS'(beat_count) == (total - TOTAL_BITS'(1)));

  assign S_Ready = (state == LOAD);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign err     = (state == DONE) && err_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      total         <= '0;
      beat_count    <= '0;
      err_flag      <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= '0;
      input_data    <= '0;
    end else begin
      write_enable <= handshake;
      if (handshake) begin
        input_data    <= S_Data;
        write_address <= beat_count;
        beat_count    <= beat_count + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            total      <= requested;
            beat_count <= '0;
            err_flag   <= too_big;
            if ((requested == '0) || too_big) begin
              state <= DONE;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (handshake && last_beat) begin
            state <= FLUSH;
          end
        end
        FLUSH:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bias_ram_loader.sv
// tb/tb_bias_ram_loader.sv - directed self-checking bench for bias_ram_loader
module tb_bias_ram_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  channel_out_groups;
  logic [63:0] S_Data;
  logic        S_Valid;
  logic        S_Ready;
  logic [63:0] input_data;
  logic [8:0]  write_address;
  logic        write_enable;
  logic        busy;
  logic        done;
  logic        err;

  bias_ram_loader #(
    .ADDR_BITS(9), .BEATS_PER_ROW(4), .GROUP_BITS(8), .AXI_WIDTH_DATA(64)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .channel_out_groups(channel_out_groups),
    .S_Data(S_Data), .S_Valid(S_Valid), .S_Ready(S_Ready),
    .input_data(input_data), .write_address(write_address),
    .write_enable(write_enable), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          passed = 0;
  int          total_checks = 0;
  int          wr_addr_q[$];
  logic [63:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          hs_cyc_q[$];
  int          last_hs;
  int          done_cnt;
  bit          ready_seen;
  logic        done_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Each tick ends just after a rising edge; the values seen belong to cycle 'cyc'.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (write_enable) begin
      wr_addr_q.push_back(int'(write_address));
      wr_data_q.push_back(input_data);
      wr_cyc_q.push_back(cyc);
    end
    if (done) done_cnt++;
    if (S_Ready) ready_seen = 1'b1;
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    hs_cyc_q.delete();
    done_cnt   = 0;
    ready_seen = 1'b0;
  endtask

  task automatic start_cmd(input int g);
    channel_out_groups = 8'(g);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int nbeats, input bit gaps, input logic [63:0] base);
    int k = 0;
    int n = 0;
    bit hs;
    while (k < nbeats && n < 5000) begin
      if (gaps && (n % 2 == 1)) begin
        S_Valid = 1'b0;
        S_Data  = 64'hDEAD_BEEF_DEAD_BEEF;
      end else begin
        S_Valid = 1'b1;
        S_Data  = base + 64'(k);
      end
      hs = S_Valid && S_Ready;
      tick();
      if (hs) begin
        last_hs = cyc - 1;
        hs_cyc_q.push_back(last_hs);
        k++;
      end
      n++;
    end
    S_Valid = 1'b0;
    check("beats_accepted", 64'(k), 64'(nbeats));
  endtask

  task automatic wait_done(output int dcyc);
    int n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check("done_seen", 64'(done), 64'd1);
    dcyc     = cyc;
    done_err = err;
  endtask

  task automatic check_writes(input string tag, input int n, input logic [63:0] base);
    check({tag, "_count"}, 64'(wr_addr_q.size()), 64'(n));
    if (wr_addr_q.size() == n) begin
      for (int i = 0; i < n; i++) begin
        check({tag, "_addr"}, 64'(wr_addr_q[i]), 64'(i));
        check({tag, "_data"}, wr_data_q[i], base + 64'(i));
        check({tag, "_lat"},  64'(wr_cyc_q[i]), 64'(hs_cyc_q[i] + 1));
      end
    end
  endtask

  initial begin
    int dc;
    int bad;
    rst = 1'b1; start = 1'b0; channel_out_groups = '0; S_Data = '0; S_Valid = 1'b0;
    clear_logs();
    tick(); tick();
    check("rst_ready", 64'(S_Ready), 0);
    check("rst_we",    64'(write_enable), 0);
    check("rst_addr",  64'(write_address), 0);
    check("rst_data",  input_data, 0);
    check("rst_busy",  64'(busy), 0);
    check("rst_done",  64'(done), 0);
    check("rst_err",   64'(err), 0);
    rst = 1'b0;
    tick();

    // groups=2, back-to-back beats with data = beat index
    clear_logs();
    start_cmd(2);
    check("t1_busy",  64'(busy), 1);
    check("t1_ready", 64'(S_Ready), 1);
    feed(8, 1'b0, 64'd0);
    check("t1_ready_drop", 64'(S_Ready), 0);
    wait_done(dc);
    check("t1_done_cyc", 64'(dc), 64'(last_hs + 2));
    check("t1_err", 64'(done_err), 0);
    check_writes("t1", 8, 64'd0);
    for (int i = 1; i < 8; i++) check("t1_consec", 64'(hs_cyc_q[i]), 64'(hs_cyc_q[0] + i));
    tick();
    check("t1_busy_fall", 64'(busy), 0);

    // groups=1 with S_Valid toggling
    clear_logs();
    start_cmd(1);
    feed(4, 1'b1, 64'hA0);
    wait_done(dc);
    check_writes("t2", 4, 64'hA0);
    for (int i = 1; i < 4; i++) check("t2_gap", 64'(hs_cyc_q[i]), 64'(hs_cyc_q[0] + 2 * i));
    tick();

    // zero and overflow commands
    clear_logs();
    S_Valid = 1'b1;
    start_cmd(0);
    check("t3_done", 64'(done), 1);
    check("t3_err",  64'(err), 0);
    check("t3_busy", 64'(busy), 1);
    tick();
    check("t3_busy_fall", 64'(busy), 0);
    start_cmd(129);
    check("t4_done", 64'(done), 1);
    check("t4_err",  64'(err), 1);
    tick();
    check("t4_done_fall", 64'(done), 0);
    tick();
    S_Valid = 1'b0;
    check("t34_no_we",    64'(wr_addr_q.size()), 0);
    check("t34_no_ready", 64'(ready_seen), 0);

    // exactly full capacity
    clear_logs();
    start_cmd(128);
    feed(512, 1'b0, 64'h1000);
    wait_done(dc);
    check("t5_done_cyc", 64'(dc), 64'(last_hs + 2));
    check("t5_err", 64'(done_err), 0);
    check("t5_count", 64'(wr_addr_q.size()), 512);
    bad = 0;
    for (int i = 0; i < wr_addr_q.size(); i++)
      if (wr_addr_q[i] != i || wr_data_q[i] != 64'h1000 + 64'(i)) bad++;
    check("t5_bad_writes", 64'(bad), 0);
    if (wr_addr_q.size() > 0) check("t5_last_addr", 64'(wr_addr_q[wr_addr_q.size() - 1]), 511);
    tick();

    // start during LOAD is dropped; start right after done is accepted
    clear_logs();
    start_cmd(1);
    feed(2, 1'b0, 64'd0);
    channel_out_groups = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_still_load", 64'(S_Ready), 1);
    feed(2, 1'b0, 64'd2);
    check("t6_ready_drop", 64'(S_Ready), 0);
    wait_done(dc);
    check_writes("t6", 4, 64'd0);
    tick();
    check("t6_idle", 64'(busy), 0);
    clear_logs();
    start_cmd(1);
    check("t6_restart", 64'(busy), 1);
    feed(4, 1'b0, 64'h50);
    wait_done(dc);
    check_writes("t6b", 4, 64'h50);
    tick();

    // reset in the middle of a load
    clear_logs();
    start_cmd(2);
    feed(3, 1'b0, 64'h30);
    rst = 1'b1;
    S_Valid = 1'b1;
    S_Data = 64'h77;
    tick();
    check("t7_ready", 64'(S_Ready), 0);
    check("t7_we",    64'(write_enable), 0);
    check("t7_addr",  64'(write_address), 0);
    check("t7_data",  input_data, 0);
    check("t7_busy",  64'(busy), 0);
    check("t7_done",  64'(done), 0);
    rst = 1'b0;
    repeat (6) tick();
    S_Valid = 1'b0;
    check("t7_writes", 64'(wr_addr_q.size()), 3);
    check("t7_no_done", 64'(done_cnt), 0);
    clear_logs();
    start_cmd(2);
    feed(8, 1'b0, 64'h200);
    wait_done(dc);
    check_writes("t7b", 8, 64'h200);
    tick();

    $display("%0d/%0d checks passed", passed, total_checks);
    $finish;
  end

endmodule

// File: doc/bias_ram_loader.md
# bias_ram_loader

Write-side controller for the 1x1 bias RAM. It accepts bias words from the AXI-stream DMA path and converts a per-layer start command into a sequence of RAM writes: write address, write enable and write data. It signals completion so the convolution sequencer can begin reading full `Channel_Out_Num`-wide bias rows. It sits between the DMA stream demux and the bias RAM write port.

## Interface
Parameters:
- `ADDR_BITS`, 9: width of the RAM write address; capacity is 2^ADDR_BITS write beats.
- `BEATS_PER_ROW`, 4: write beats per read row, equal to `Channel_Out_Num`*32/`AXI_WIDTH_DATA` (8*32/64).
- `GROUP_BITS`, 8: width of the group-count command field.

Ports:
- `clk` input 1: single clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: single-cycle load command; ignored unless idle.
- `channel_out_groups` input GROUP_BITS: number of `Channel_Out_Num`-channel groups to load; sampled on an accepted `start`.
- `S_Data` input `AXI_WIDTH_DATA`: bias stream data, two 32-bit biases per beat, low half first.
- `S_Valid` input 1: stream data valid.
- `S_Ready` output 1: loader accepts a beat.
- `input_data` output `AXI_WIDTH_DATA`: RAM write data.
- `write_address` output ADDR_BITS: RAM write address.
- `write_enable` output 1: RAM write strobe.
- `busy` output 1: high from an accepted `start` until the `done` cycle, inclusive.
- `done` output 1: one-cycle pulse when all writes are committed.
- `err` output 1: one-cycle pulse, coincident with `done`, when the command exceeds capacity.

## Operation
- FSM states: IDLE, LOAD, FLUSH, DONE.
- IDLE: `S_Ready`=0. An accepted `start` latches total = `channel_out_groups`*`BEATS_PER_ROW`, computed at ADDR_BITS+GROUP_BITS width with no truncation, and clears the beat counter.
  - total = 0 goes to DONE with `err`=0.
  - total > 2^ADDR_BITS goes to DONE with `err`=1. No write is issued and no beat is consumed.
  - Any other total goes to LOAD.
- LOAD: `S_Ready`=1.
  - Each handshake (`S_Valid`&`S_Ready`) registers `S_Data` into `input_data`, registers the counter into `write_address`, pulses `write_enable` the next cycle, and increments the counter.
  - The handshake of beat total-1 moves the FSM to FLUSH, and `S_Ready` drops in the following cycle.
- FLUSH: the final `write_enable` is high this cycle; next state DONE.
- DONE: `done`=1 (and `err` if flagged), `busy`=1; next state IDLE.
- Addresses always start at 0 and increment by 1. Beat k is written to address k.
  - The counter wraps only at 2^ADDR_BITS, which is unreachable given the capacity check.
  - A total of exactly 2^ADDR_BITS is legal; the last address is all-ones.
- `start` while busy is dropped, not queued.
- `S_Valid` gaps are legal. The counter and FSM hold, `write_enable`=0.
- Beats presented while IDLE are not consumed (`S_Ready`=0).

## Timing
- Reset values: `S_Ready`=0, `write_enable`=0, `write_address`=0, `input_data`=0, `busy`=0, `done`=0, `err`=0; state IDLE.
- `start` at cycle t: `busy`=1 and `S_Ready`=1 at t+1.
- A handshake at cycle c gives `write_enable`=1 at c+1, with `write_address`/`input_data` valid at c+1. Latency is one cycle.
- Last handshake at c: `S_Ready`=0 at c+1, `done` at c+2, `busy`=0 at c+3.
- Back-to-back loads: a `start` at the cycle `busy` falls is accepted.
- Zero or overflow command at t: `done`(/`err`) at t+1.
- `rst` mid-load: on the next edge, all outputs take reset values, pending writes are discarded, and there is no `done`. The RAM retains any already-written words.

## Test plan
- groups=2, `S_Valid` held high, data=beat index → 8 writes at addresses 0..7 on consecutive cycles, data 0..7; `done` 2 cycles after the 8th handshake; `err`=0.
- groups=1 with `S_Valid` toggling 1,0,1,0 → 4 writes at addresses 0..3 only in cycles following valid beats; no write in gap cycles.
- groups=0 → `done` 1 cycle after `start`, no `write_enable`, `S_Ready` never high.
- groups=129 (516 > 512) → `done`+`err` 1 cycle after `start`, no writes, `S_Ready` never high. groups=128 → 512 writes, last address 511, `err`=0.
- `start` pulsed again during LOAD → ignored, beat count unchanged. A new `start` in the cycle after `done` is accepted, and addressing restarts at 0.
- `rst` asserted after the 3rd handshake of groups=2 → all outputs 0 next cycle, no further writes, no `done`. A subsequent `start` loads normally from address 0.
